icache_resp: RTL and testbench
==============================

Name: icache_resp

Overview:
- Instruction-cache responder: the icache end of the req_cpu_icache_t / req_icache_cpu_t interface driven by the fetch stage.
- Small direct-mapped line cache; on a miss, refills one line from the memory/L2 port over a valid/ready handshake.
- Returns the 32-bit instruction plus fault flags.
- Sits between the fetch stage and the memory hierarchy.

Parameters:
- NUM_LINES, 4, number of direct-mapped lines (power of 2, ≥2).
- LINE_BYTES, 16, line size in bytes (fixed 128-bit refill beat).
- PADDR_WIDTH, 32, implemented physical address bits; vaddr bits above are illegal.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- req_cpu_icache_i  in  req_cpu_icache_t  {valid, vaddr[39:0]} from fetch
- req_icache_cpu_o  out  req_icache_cpu_t  {valid, data[31:0], instr_access_fault, instr_addr_misaligned, instr_page_fault} to fetch
- flush_i  in  1  invalidate all lines (fence.i)
- mem_req_valid_o  out  1  refill request valid
- mem_req_ready_i  in  1  refill request accepted
- mem_req_addr_o  out  PADDR_WIDTH  line-aligned refill address
- mem_resp_valid_i  in  1  refill data beat valid
- mem_resp_data_i  in  128  refill line, little-endian words
- mem_resp_error_i  in  1  bus error on refill (qualifies mem_resp_valid_i)

Behaviour:
- Reset: all line valid bits 0; FSM IDLE; req_icache_cpu_o all fields 0; mem_req_valid_o 0; mem_req_addr_o 0.
- Address split:
  - offset = vaddr[3:2] (word select)
  - idx = vaddr[4+log2(NUM_LINES)-1:4]
  - tag = vaddr[PADDR_WIDTH-1:4+log2(NUM_LINES)]
- Fetch holds vaddr stable while waiting; every cycle with valid=1 is a lookup.
- FSM states IDLE, REQ, WAIT.
- IDLE, input valid:
  - vaddr[1:0]!=0 → next cycle: valid=1, instr_addr_misaligned=1, data=0; no memory access.
  - else |vaddr[39:PADDR_WIDTH] → next cycle: valid=1, instr_access_fault=1; no memory access.
  - else hit (valid bit and tag match) → next cycle: valid=1, data=selected word (latency 1).
  - else miss → REQ; mem_req_addr_o={vaddr[PADDR_WIDTH-1:4],4'b0}; response valid stays 0.
- REQ: mem_req_valid_o=1 and addr held until mem_req_ready_i; then → WAIT. A request once asserted is never withdrawn.
- WAIT, on mem_resp_valid_i:
  - no error → write data, tag, valid bit into the line; → IDLE. The held request then hits on the next lookup, so miss latency = handshake + 2 cycles.
  - error → line not written; next cycle valid=1, instr_access_fault=1; → IDLE.
- Output valid is a 1-cycle pulse per completed lookup; it repeats every cycle while input valid stays high and hits.
- instr_page_fault is always 0 (no MMU in this block).
- Fault priority: misaligned > access fault.
- vaddr changes during REQ/WAIT (redirect): refill completes and is installed; no response for the old address; new address looked up in IDLE.
- flush_i at cycle t:
  - all valid bits clear at edge t+1.
  - a hit response due at t+1 is suppressed.
  - a refill in progress completes the handshake, but its data is discarded, not installed.
  - flush has priority over an install in the same cycle.
- Input valid=0: no lookup; response valid=0 next cycle.
- Reset mid-refill: FSM to IDLE, outputs to reset values; memory side must tolerate the dropped transaction.

Optional Feature:
- Macro ICACHE_PERF_CNT_EN.
- Defined: adds outputs hit_cnt_o[31:0] and miss_cnt_o[31:0].
  - Hit counter increments once per hit response; miss counter once per REQ entry.
  - Both saturate at 32'hFFFF_FFFF, reset to 0, and are not cleared by flush_i.
- Not defined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- drac_pkg:
  - icache_state_t enum {IDLE, REQ, WAIT}
  - icache_line_t (128-bit)
  - ICACHE_LINE_BYTES, ICACHE_NUM_LINES constants
  - req_cpu_icache_t and req_icache_cpu_t stay shared.
- Sub-module icache_tag_data_array:
  - flop-based tag/data/valid storage.
  - async read by idx; sync write; bulk valid clear.

Test Plan:
- Cold miss at vaddr 0x100: mem_req_addr_o=0x100 once; respond data 0x...00000013 words → next lookup returns data=word0, valid=1; hit_cnt=1, miss_cnt=1.
- Sequential 0x100, 0x104, 0x108, 0x10C after fill → four consecutive 1-cycle hits, no mem_req_valid_o.
- vaddr 0x102 → next cycle valid=1, instr_addr_misaligned=1, mem_req_valid_o never asserted; vaddr 0x1_0000_0000 → instr_access_fault=1.
- Miss with mem_req_ready_i held low 5 cycles → mem_req_valid_o and addr stable for all 5; mem_resp_error_i=1 → instr_access_fault=1, same address misses again.
- flush_i during WAIT for 0x200 → refill completes, line not installed, following lookup of 0x200 misses again.
- Alias: fill 0x100, then 0x140 (same idx, NUM_LINES=4) → miss, evicts; 0x100 misses again.

Source files
------------

// File: rtl/drac_pkg.sv
// Shared fetch/icache types and icache constants.
package drac_pkg;

  localparam int ICACHE_LINE_BYTES = 16;
  localparam int ICACHE_NUM_LINES  = 4;

  typedef logic [127:0] icache_line_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } icache_state_t;

  typedef struct packed {
    logic        valid;
    logic [39:0] vaddr;
  } req_cpu_icache_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
    logic        instr_access_fault;
    logic        instr_addr_misaligned;
    logic        instr_page_fault;
  } req_icache_cpu_t;

  function automatic logic [31:0] icache_word_sel(input icache_line_t line, input logic [1:0] off);
    return line[32*int'(off) +: 32];
  endfunction

endpackage

// File: rtl/icache_tag_data_array.sv
// Flop-based tag/data/valid storage for the direct-mapped icache.
// Asynchronous read by index, synchronous write, bulk valid clear.
import drac_pkg::*;

module icache_tag_data_array #(
  parameter int NUM_LINES = 4,
  parameter int TAG_W     = 26,
  localparam int IDX_W    = $clog2(NUM_LINES)
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output icache_line_t      rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  icache_line_t      wr_data,
  input  logic              clr_all
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  icache_line_t         data_q [NUM_LINES];

  // Clear wins over a same-cycle write so a flushed line never comes back valid.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_q <= '0;
    end else if (clr_all) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/icache_resp.sv
// Direct-mapped instruction cache responder with single-line refill.
// Optional hit/miss counters under ICACHE_PERF_CNT_EN.
//   state | meaning
//   IDLE  | lookups accepted, responses issued
//   REQ   | refill request held until accepted
//   WAIT  | waiting for the refill beat
import drac_pkg::*;

module icache_resp #(
  parameter int NUM_LINES   = ICACHE_NUM_LINES,
  parameter int LINE_BYTES  = ICACHE_LINE_BYTES,
  parameter int PADDR_WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  req_cpu_icache_t        req_cpu_icache_i,
  output req_icache_cpu_t        req_icache_cpu_o,
  input  logic                   flush_i,
  output logic                   mem_req_valid_o,
  input  logic                   mem_req_ready_i,
  output logic [PADDR_WIDTH-1:0] mem_req_addr_o,
  input  logic                   mem_resp_valid_i,
  input  logic [127:0]           mem_resp_data_i,
  input  logic                   mem_resp_error_i
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]            hit_cnt_o,
  output logic [31:0]            miss_cnt_o
`endif
);

  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int LINE_W = PADDR_WIDTH - OFF_W;
  localparam int TAG_W  = LINE_W - IDX_W;

  icache_state_t   state_q, state_d;
  req_icache_cpu_t resp_q, resp_d;
  logic [LINE_W-1:0] refill_line_q;
  logic            discard_q;
  logic            miss_start, install, hit_rsp;

  logic [39:0]      vaddr;
  logic             misaligned, addr_fault, hit;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  icache_line_t     rd_data;

  assign vaddr      = req_cpu_icache_i.vaddr;
  assign misaligned = |vaddr[1:0];
  assign addr_fault = |vaddr[39:PADDR_WIDTH];
  assign idx        = vaddr[OFF_W +: IDX_W];
  assign tag        = vaddr[PADDR_WIDTH-1 -: TAG_W];
  assign hit        = rd_valid && (rd_tag == tag);

  icache_tag_data_array #(
    .NUM_LINES (NUM_LINES),
    .TAG_W     (TAG_W)
  ) u_array (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .rd_idx   (idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (install),
    .wr_idx   (refill_line_q[IDX_W-1:0]),
    .wr_tag   (refill_line_q[LINE_W-1 -: TAG_W]),
    .wr_data  (mem_resp_data_i),
    .clr_all  (flush_i)
  );

  always_comb begin
    state_d    = state_q;
    resp_d     = '0;
    miss_start = 1'b0;
    install    = 1'b0;
    hit_rsp    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_cpu_icache_i.valid) begin
          if (misaligned) begin
            resp_d.valid                 = 1'b1;
            resp_d.instr_addr_misaligned = 1'b1;
          end else if (addr_fault) begin
            resp_d.valid              = 1'b1;
            resp_d.instr_access_fault = 1'b1;
          end else if (hit) begin
            if (!flush_i) begin
              hit_rsp      = 1'b1;
              resp_d.valid = 1'b1;
              resp_d.data  = icache_word_sel(rd_data, vaddr[3:2]);
            end
          end else begin
            state_d    = REQ;
            miss_start = 1'b1;
          end
        end
      end
      REQ: begin
        if (mem_req_ready_i) state_d = WAIT;
      end
      WAIT: begin
        if (mem_resp_valid_i) begin
          state_d = IDLE;
          if (mem_resp_error_i) begin
            // Fault is reported only if fetch is still asking for the failed line.
            if (req_cpu_icache_i.valid && (vaddr[PADDR_WIDTH-1:OFF_W] == refill_line_q)) begin
              resp_d.valid              = 1'b1;
              resp_d.instr_access_fault = 1'b1;
            end
          end else begin
            install = !flush_i && !discard_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q       <= IDLE;
      resp_q        <= '0;
      refill_line_q <= '0;
      discard_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      resp_q  <= resp_d;
      if (miss_start) refill_line_q <= vaddr[PADDR_WIDTH-1:OFF_W];
      if (state_q == IDLE) discard_q <= 1'b0;
      else if (flush_i)    discard_q <= 1'b1;
    end
  end

  assign req_icache_cpu_o = resp_q;
  assign mem_req_valid_o  = (state_q == REQ);
  assign mem_req_addr_o   = {refill_line_q, {OFF_W{1'b0}}};

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_rsp && (hit_cnt_q != 32'hFFFF_FFFF))     hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_start && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_resp.sv
// Scoreboard bench for icache_resp: directed lookups, refills, faults and flushes.
// Counter checks are compiled in when ICACHE_PERF_CNT_EN is defined.
import drac_pkg::*;

module tb_icache_resp;

  logic            clk_i = 1'b0;
  logic            rstn_i;
  req_cpu_icache_t req;
  req_icache_cpu_t rsp;
  logic            flush_i;
  logic            mem_req_valid_o;
  logic            mem_req_ready_i;
  logic [31:0]     mem_req_addr_o;
  logic            mem_resp_valid_i;
  logic [127:0]    mem_resp_data_i;
  logic            mem_resp_error_i;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0]     hit_cnt, miss_cnt;
`endif

  req_icache_cpu_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int mem_req_cycles = 0;

  always #5 clk_i = ~clk_i;

  icache_resp #(.NUM_LINES(4), .LINE_BYTES(16), .PADDR_WIDTH(32)) dut (
    .clk_i            (clk_i),
    .rstn_i           (rstn_i),
    .req_cpu_icache_i (req),
    .req_icache_cpu_o (rsp),
    .flush_i          (flush_i),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_req_addr_o   (mem_req_addr_o),
    .mem_resp_valid_i (mem_resp_valid_i),
    .mem_resp_data_i  (mem_resp_data_i),
    .mem_resp_error_i (mem_resp_error_i)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_cnt_o        (hit_cnt),
    .miss_cnt_o       (miss_cnt)
`endif
  );

  // Word k of the line at base b is {b[19:0], k, 8'h13}; e.g. 0x104 -> 32'h00100113.
  function automatic logic [31:0] word_of(input logic [39:0] a);
    logic [39:0] b;
    b = {a[39:4], 4'h0};
    return {b[19:0], 2'b00, a[3:2], 8'h13};
  endfunction

  function automatic logic [127:0] line_of(input logic [39:0] a);
    logic [127:0] l;
    logic [39:0]  w;
    for (int k = 0; k < 4; k++) begin
      w = {a[39:4], 4'h0} + 40'(4 * k);
      l[32*k +: 32] = word_of(w);
    end
    return l;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_hit(input logic [39:0] a);
    req_icache_cpu_t e;
    e = '0;
    e.valid = 1'b1;
    e.data  = word_of(a);
    exp_q.push_back(e);
  endtask

  task automatic push_fault(input logic mis);
    req_icache_cpu_t e;
    e = '0;
    e.valid = 1'b1;
    if (mis) e.instr_addr_misaligned = 1'b1;
    else     e.instr_access_fault    = 1'b1;
    exp_q.push_back(e);
  endtask

  // Memory side: wait for the request, hold off 'delay' cycles, then return one beat.
  task automatic refill(input logic [31:0] exp_addr, input int delay, input logic err,
                        input logic flush_wait);
    int n;
    logic [31:0] held;
    n = 0;
    while (!mem_req_valid_o && n < 20) begin
      step();
      n++;
    end
    check("req_valid_seen", 64'(mem_req_valid_o), 64'd1);
    if (!mem_req_valid_o) return;
    check("req_addr", 64'(mem_req_addr_o), 64'(exp_addr));
    held = mem_req_addr_o;
    for (int i = 0; i < delay; i++) begin
      step();
      check("req_hold_valid", 64'(mem_req_valid_o), 64'd1);
      check("req_hold_addr", 64'(mem_req_addr_o), 64'(held));
    end
    mem_req_ready_i = 1'b1;
    step();
    mem_req_ready_i = 1'b0;
    check("req_drop", 64'(mem_req_valid_o), 64'd0);
    if (flush_wait) begin
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
    end
    mem_resp_valid_i = 1'b1;
    mem_resp_error_i = err;
    mem_resp_data_i  = line_of({8'h00, exp_addr});
    step();
    mem_resp_valid_i = 1'b0;
    mem_resp_error_i = 1'b0;
  endtask

  // Miss, successful refill, then exactly one hit lookup of the held address.
  task automatic do_fill(input logic [39:0] a);
    req.valid = 1'b1;
    req.vaddr = a;
    push_hit(a);
    refill({a[31:4], 4'h0}, 0, 1'b0, 1'b0);
    step();
    req.valid = 1'b0;
  endtask

  initial begin : monitor
    req_icache_cpu_t e;
    forever begin
      @(negedge clk_i);
      if (rstn_i === 1'b1) begin
        if (mem_req_valid_o) mem_req_cycles++;
        if (rsp.valid) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_rsp: got %h expected none", rsp);
          end else begin
            e = exp_q.pop_front();
            if (rsp !== e) begin
              miscompares++;
              $display("FAIL rsp: got %h expected %h", rsp, e);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int snap;
    rstn_i = 1'b0;
    req = '0;
    flush_i = 1'b0;
    mem_req_ready_i = 1'b0;
    mem_resp_valid_i = 1'b0;
    mem_resp_data_i = '0;
    mem_resp_error_i = 1'b0;
    repeat (3) step();
    check("rst_rsp", 64'(rsp), 64'd0);
    check("rst_req_valid", 64'(mem_req_valid_o), 64'd0);
    check("rst_req_addr", 64'(mem_req_addr_o), 64'd0);
    rstn_i = 1'b1;
    step();

    // Cold miss then hit at 0x100
    do_fill(40'h100);
    step();
`ifdef ICACHE_PERF_CNT_EN
    check("hit_cnt_cold", 64'(hit_cnt), 64'd1);
    check("miss_cnt_cold", 64'(miss_cnt), 64'd1);
`endif

    // Back-to-back hits across the line
    snap = mem_req_cycles;
    req.valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req.vaddr = 40'h100 + 40'(4 * i);
      push_hit(req.vaddr);
      step();
    end
    req.valid = 1'b0;
    repeat (2) step();
    check("seq_no_mem", 64'(mem_req_cycles), 64'(snap));

    // Misaligned and out-of-range addresses
    snap = mem_req_cycles;
    req.valid = 1'b1;
    req.vaddr = 40'h102;
    push_fault(1'b1);
    step();
    req.vaddr = 40'h01_0000_0000;
    push_fault(1'b0);
    step();
    req.vaddr = 40'h01_0000_0002;
    push_fault(1'b1);
    step();
    req.valid = 1'b0;
    repeat (3) step();
    check("fault_no_mem", 64'(mem_req_cycles), 64'(snap));

    // Stalled request then bus error; same address must miss again
    req.valid = 1'b1;
    req.vaddr = 40'h1A4;
    push_fault(1'b0);
    refill(32'h1A0, 5, 1'b1, 1'b0);
    req.valid = 1'b0;
    step();
    do_fill(40'h1A4);
    step();

    // Flush during WAIT discards the refill
    req.valid = 1'b1;
    req.vaddr = 40'h200;
    refill(32'h200, 0, 1'b0, 1'b1);
    req.valid = 1'b0;
    repeat (2) step();
    do_fill(40'h200);
    step();

    // Flush in the lookup cycle suppresses the hit and invalidates the line
    req.valid = 1'b1;
    req.vaddr = 40'h200;
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    req.valid = 1'b0;
    repeat (2) step();
    do_fill(40'h200);
    step();

    // Aliasing lines in the same index evict each other
    do_fill(40'h100);
    step();
    do_fill(40'h140);
    step();
    do_fill(40'h100);
    repeat (3) step();

    check("queue_empty", 64'(exp_q.size()), 64'd0);
`ifdef ICACHE_PERF_CNT_EN
    check("hit_cnt_end", 64'(hit_cnt), 64'd11);
    check("miss_cnt_end", 64'(miss_cnt), 64'd9);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
